wishbone_data_if: RTL and testbench
===================================

# wishbone_data_if

Wishbone B4 classic master bridge between the openmips core data-memory port (`mem_ce_o`/`mem_we_o`/`mem_addr_o`/`mem_sel_o`/`mem_data_o`/`mem_data_i`) and a shared Wishbone interconnect. It replaces the direct core-to-`data_ram` connection in the SOPC top.
- Converts each single-cycle core access into one Wishbone cycle.
- Requests a pipeline stall until the slave acknowledges.
- Holds read data while the pipeline remains stalled by other stages.

## Interface
Parameters:
- `TIMEOUT`, 255: max BUSY cycles without `ack`; 0 disables the watchdog.
- `CNT_W`, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_ce_i` in 1: core requests access this cycle.
- `cpu_we_i` in 1: 1 = write, 0 = read.
- `cpu_addr_i` in 32: byte address.
- `cpu_sel_i` in 4: byte lanes.
- `cpu_data_i` in 32: write data.
- `cpu_data_o` out 32: read data to the MEM stage.
- `stall_i` in 6: pipeline stall vector from ctrl.
- `flush_i` in 1: pipeline flush (exception).
- `stallreq_o` out 1: stall request to ctrl.
- `bus_err_o` out 1: one-cycle pulse on watchdog abort.
- `wb_cyc_o` out 1, `wb_stb_o` out 1, `wb_we_o` out 1: Wishbone master controls, registered.
- `wb_adr_o` out 32, `wb_sel_o` out 4, `wb_dat_o` out 32: Wishbone master address, byte select and write data, registered.
- `wb_dat_i` in 32: slave read data.
- `wb_ack_i` in 1: slave acknowledge.

## Operation
- Registered outputs: `wb_*_o`, `bus_err_o`, read buffer `rd_buf`, watchdog counter `wd_cnt`, state.
- Combinational outputs: `stallreq_o`, `cpu_data_o`.
- Reset: state = IDLE; `rd_buf`, `wd_cnt` and all `wb_*_o` = 0; `bus_err_o` = 0.
- FSM states: IDLE, BUSY, WAIT_STALL.

IDLE:
- If `cpu_ce_i && !flush_i`:
  - Register `cyc`=`stb`=1 and `adr`/`sel`/`we`/`dat` from the `cpu_*` inputs.
  - Clear `rd_buf` and `wd_cnt`.
  - Go to BUSY.
- Combinational outputs: `stallreq_o = cpu_ce_i && !flush_i`; `cpu_data_o = 0`.

BUSY:
- Wishbone outputs are held stable until the cycle ends.
- `flush_i` has priority over `ack`:
  - Drop `cyc`/`stb`, zero all `wb_*_o`, go to IDLE.
  - `stallreq_o` = 0; `rd_buf` unchanged.
- Else if `wb_ack_i`:
  - Drop `cyc`/`stb` and zero all `wb_*_o`.
  - On a read, `rd_buf <= wb_dat_i`.
  - Next state: WAIT_STALL if `stall_i != 0`, else IDLE.
  - `stallreq_o` = 0; `cpu_data_o = we ? 0 : wb_dat_i`.
- Else if `TIMEOUT != 0 && wd_cnt == TIMEOUT-1`:
  - Abort: drop `cyc`/`stb` and zero all `wb_*_o`.
  - Pulse `bus_err_o` = 1 for the next cycle.
  - `stallreq_o` = 0; `cpu_data_o` = 0.
  - Next state as in the `ack` case.
- Else: `wd_cnt++`; `stallreq_o` = 1; `cpu_data_o` = 0.

WAIT_STALL:
- `stallreq_o` = 0; `cpu_data_o = rd_buf`.
- Go to IDLE when `stall_i == 0`.
- `flush_i` forces IDLE.
- A new `cpu_ce_i` is not accepted in this state.

Other rules:
- `wd_cnt` saturates at TIMEOUT-1 and never wraps.
- `wb_ack_i` is ignored outside BUSY.
- At most one outstanding Wishbone cycle; no pipelined or burst transfers.

## Timing
- Access latency: `cyc` rises 1 cycle after `cpu_ce_i` is sampled in IDLE.
- Zero-wait-state slave (`ack` in the first BUSY cycle): `stallreq_o` high for exactly 1 cycle; read data is valid on `cpu_data_o` in the second cycle of the request.
- N wait states: `stallreq_o` high for N+1 cycles.
- `stallreq_o` falls combinationally in the same cycle `wb_ack_i` is seen.
- Back-to-back accesses: a new `cpu_ce_i` is accepted in the cycle IDLE is re-entered; there is always ≥1 idle bus cycle (`cyc`=0) between transfers.
- `bus_err_o` asserts the cycle after the timeout cycle and lasts exactly 1 cycle.
- Reset asserted mid-transaction: `cyc`/`stb` drop immediately (asynchronously); state returns to IDLE with no error pulse.

## Test plan
- Read, zero-wait slave: addr 0x0000_0010, slave returns 0xDEAD_BEEF with `ack` in the first BUSY cycle, `stall_i`=0 -> `cyc` high 1 cycle, `stallreq_o` high 1 cycle, `cpu_data_o`=0xDEAD_BEEF in the `ack` cycle.
- Write, 3 wait states: addr 0x20, `sel`=4'b0011, data 0x1234_5678 -> `wb_dat_o`/`wb_sel_o`/`wb_adr_o` stable for 4 cycles, `stallreq_o` high 4 cycles, `cpu_data_o`=0 throughout.
- Read `ack` while `stall_i`=6'b000011 held 3 more cycles, slave returns 0xA5A5_0001 -> FSM in WAIT_STALL; `cpu_data_o`=0xA5A5_0001 for all 3 cycles; IDLE once `stall_i`=0.
- `flush_i` in the second BUSY cycle, `ack` arriving in the same cycle -> flush wins: `cyc` drops, `rd_buf` not loaded, IDLE next cycle, `stallreq_o`=0.
- TIMEOUT=4, slave never acks -> `cyc` high exactly 4 cycles, `bus_err_o` pulses 1 cycle, `cpu_data_o`=0; next access proceeds normally.
- `rst` asserted while BUSY -> `cyc`/`stb`/`stallreq_o` go to 0 without waiting for a clock edge; after release, IDLE and the next read completes correctly.

Source files
------------

// File: rtl/wishbone_data_if.sv
// -----------------------------------------------------------------------------
// wishbone_data_if
//
// Wishbone B4 classic master bridge for the openmips data-memory port.  Each
// single-cycle core access becomes exactly one Wishbone cycle.  The core is
// stalled until the slave acknowledges (or the watchdog aborts).  Read data is
// held for the MEM stage while other pipeline stages keep the core stalled.
//
// Handshake: the core presents a request by holding cpu_ce_i high.  A request
// sampled in IDLE (and not flushed) starts a Wishbone cycle on the next clock
// edge.  stallreq_o stays high until the cycle ends: wb_ack_i high while
// wb_cyc_o/wb_stb_o are high completes the transfer in that same clock,
// flush_i abandons it, or the watchdog aborts it after TIMEOUT cycles.  Only
// one Wishbone cycle is ever outstanding and there is always at least one idle
// bus cycle between transfers.
//
// Parameters:
//   TIMEOUT     max BUSY cycles without ack before abort; 0 disables watchdog
//   CNT_W       watchdog counter width, 2**CNT_W must exceed TIMEOUT
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   cpu_ce_i/we_i     core access request / write enable
//   cpu_addr_i        byte address
//   cpu_sel_i         byte lanes
//   cpu_data_i        write data
//   cpu_data_o        read data to the MEM stage (combinational)
//   stall_i           pipeline stall vector from ctrl
//   flush_i           pipeline flush
//   stallreq_o        stall request to ctrl (combinational)
//   bus_err_o         one-cycle pulse after a watchdog abort
//   wb_*_o            registered Wishbone master outputs
//   wb_dat_i/ack_i    Wishbone slave read data / acknowledge
//   dbg_state_o       FSM state: 0 = IDLE, 1 = BUSY, 2 = WAIT_STALL
// -----------------------------------------------------------------------------
module wishbone_data_if #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_ce_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [3:0]  cpu_sel_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   input  logic [5:0]  stall_i,
   input  logic        flush_i,
   output logic        stallreq_o,
   output logic        bus_err_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_adr_o,
   output logic [3:0]  wb_sel_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   output logic [1:0]  dbg_state_o
);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_BUSY       = 2'd1,
      S_WAIT_STALL = 2'd2
   } state_e;

   // Watchdog terminal count; unused (held at zero) when the watchdog is off.
   localparam bit               WD_EN   = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] WD_LAST = WD_EN ? CNT_W'(TIMEOUT - 1) : '0;

   state_e            state_q,   state_d;
   logic              cyc_q,     cyc_d;
   logic              stb_q,     stb_d;
   logic              we_q,      we_d;
   logic [31:0]       adr_q,     adr_d;
   logic [3:0]        sel_q,     sel_d;
   logic [31:0]       dat_q,     dat_d;
   logic [31:0]       rd_buf_q,  rd_buf_d;
   logic [CNT_W-1:0]  wd_cnt_q,  wd_cnt_d;
   logic              bus_err_q, bus_err_d;

   logic              stallreq_c;
   logic              end_cycle;
   logic              wd_expired;

   assign wd_expired = WD_EN && (wd_cnt_q == WD_LAST);

   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      stb_d      = stb_q;
      we_d       = we_q;
      adr_d      = adr_q;
      sel_d      = sel_q;
      dat_d      = dat_q;
      rd_buf_d   = rd_buf_q;
      wd_cnt_d   = wd_cnt_q;
      bus_err_d  = 1'b0;
      stallreq_c = 1'b0;
      cpu_data_o = '0;
      end_cycle  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu_ce_i && !flush_i) begin
               stallreq_c = 1'b1;
               cyc_d      = 1'b1;
               stb_d      = 1'b1;
               we_d       = cpu_we_i;
               adr_d      = cpu_addr_i;
               sel_d      = cpu_sel_i;
               dat_d      = cpu_data_i;
               rd_buf_d   = '0;
               wd_cnt_d   = '0;
               state_d    = S_BUSY;
            end
         end

         S_BUSY: begin
            if (flush_i) begin
               // Flush beats a simultaneous ack: the access is abandoned and
               // the read buffer keeps its old contents.
               end_cycle = 1'b1;
               state_d   = S_IDLE;
            end else if (wb_ack_i) begin
               end_cycle  = 1'b1;
               cpu_data_o = we_q ? 32'h0 : wb_dat_i;
               if (!we_q) begin
                  rd_buf_d = wb_dat_i;
               end
               state_d = (stall_i != '0) ? S_WAIT_STALL : S_IDLE;
            end else if (wd_expired) begin
               end_cycle = 1'b1;
               bus_err_d = 1'b1;
               state_d   = (stall_i != '0) ? S_WAIT_STALL : S_IDLE;
            end else begin
               stallreq_c = 1'b1;
               // Saturating count; never wraps past the terminal value.
               if (WD_EN && (wd_cnt_q != WD_LAST)) begin
                  wd_cnt_d = wd_cnt_q + CNT_W'(1);
               end
            end
         end

         S_WAIT_STALL: begin
            // Present the captured read data until the pipeline moves on.
            cpu_data_o = rd_buf_q;
            if (flush_i || (stall_i == '0)) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (end_cycle) begin
         cyc_d = 1'b0;
         stb_d = 1'b0;
         we_d  = 1'b0;
         adr_d = '0;
         sel_d = '0;
         dat_d = '0;
      end
   end

   // Reset also masks the stall request, so a core still holding cpu_ce_i
   // during reset does not see a stall.
   assign stallreq_o = stallreq_c && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cyc_q     <= 1'b0;
         stb_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         dat_q     <= '0;
         rd_buf_q  <= '0;
         wd_cnt_q  <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         stb_q     <= stb_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         dat_q     <= dat_d;
         rd_buf_q  <= rd_buf_d;
         wd_cnt_q  <= wd_cnt_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = stb_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_sel_o    = sel_q;
   assign wb_dat_o    = dat_q;
   assign bus_err_o   = bus_err_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wishbone_data_if.sv
// -----------------------------------------------------------------------------
// tb_wishbone_data_if
//
// Bench for wishbone_data_if built with TIMEOUT = 4.  Each transaction is a
// record of stimulus (access, slave wait states, pipeline stall length) plus
// the expected outcome: read data seen by the core, number of cycles cyc is
// high and whether the watchdog fires.  Table rows carry hand-derived
// expectations; random rows get theirs from a transaction-level model.
// -----------------------------------------------------------------------------
module tb_wishbone_data_if;

   localparam int unsigned TO = 4;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;

   logic        clk;
   logic        rst;
   logic        cpu_ce_i;
   logic        cpu_we_i;
   logic [31:0] cpu_addr_i;
   logic [3:0]  cpu_sel_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic        stallreq_o;
   logic        bus_err_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_o;
   logic [31:0] wb_dat_i;
   logic        wb_ack_i;
   logic [1:0]  dbg_state_o;

   int n_cmp = 0;
   int n_err = 0;

   wishbone_data_if #(.TIMEOUT(TO), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_ce_i    (cpu_ce_i),
      .cpu_we_i    (cpu_we_i),
      .cpu_addr_i  (cpu_addr_i),
      .cpu_sel_i   (cpu_sel_i),
      .cpu_data_i  (cpu_data_i),
      .cpu_data_o  (cpu_data_o),
      .stall_i     (stall_i),
      .flush_i     (flush_i),
      .stallreq_o  (stallreq_o),
      .bus_err_o   (bus_err_o),
      .wb_cyc_o    (wb_cyc_o),
      .wb_stb_o    (wb_stb_o),
      .wb_we_o     (wb_we_o),
      .wb_adr_o    (wb_adr_o),
      .wb_sel_o    (wb_sel_o),
      .wb_dat_o    (wb_dat_o),
      .wb_dat_i    (wb_dat_i),
      .wb_ack_i    (wb_ack_i),
      .dbg_state_o (dbg_state_o)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "bench time limit");
   end

   // ---------------------------------------------------------------- records
   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  sel;
      logic [31:0] wdata;
      logic [31:0] rdata;      // slave read data returned with ack
      int          n_wait;     // slave wait states before ack
      int          n_stall;    // cycles stall_i is nonzero from the end cycle
      logic [31:0] exp_rd;     // data the core sees at end and while held
      int          exp_busy;   // cycles wb_cyc_o is high
      logic        exp_err;    // watchdog abort expected
   } vec_t;

   vec_t tbl[8];

   // Transaction-level reference: slave answers after n_wait wait states
   // unless the watchdog allows fewer than n_wait+1 bus cycles.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      bit timed_out;
      r = v;
      timed_out  = (v.n_wait + 1 > int'(TO));
      r.exp_err  = timed_out;
      r.exp_busy = timed_out ? int'(TO) : v.n_wait + 1;
      r.exp_rd   = (v.we || timed_out) ? 32'h0 : v.rdata;
      return r;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      cpu_ce_i   = 1'b0;
      cpu_we_i   = 1'b0;
      cpu_addr_i = '0;
      cpu_sel_i  = '0;
      cpu_data_i = '0;
      stall_i    = '0;
      flush_i    = 1'b0;
      wb_ack_i   = 1'b0;
      wb_dat_i   = '0;
   endtask

   task automatic run_xact(input vec_t v, input string tag);
      // Request cycle in IDLE.
      next_cycle();
      cpu_ce_i   = 1'b1;
      cpu_we_i   = v.we;
      cpu_addr_i = v.addr;
      cpu_sel_i  = v.sel;
      cpu_data_i = v.wdata;
      stall_i    = '0;
      flush_i    = 1'b0;
      wb_ack_i   = 1'b0;
      wb_dat_i   = $urandom;
      sample();
      chk({tag, ".req_stallreq"}, 32'(stallreq_o), 32'd1);
      chk({tag, ".req_cyc"},      32'(wb_cyc_o),   32'd0);
      chk({tag, ".req_data"},     cpu_data_o,      32'h0);

      // Bus cycles; the core keeps its request up while stalled.
      for (int b = 0; b < v.exp_busy; b++) begin
         next_cycle();
         wb_ack_i = (b == v.n_wait);
         wb_dat_i = (b == v.n_wait) ? v.rdata : $urandom;
         if (b == v.exp_busy - 1) stall_i = (v.n_stall > 0) ? 6'b000011 : 6'b0;
         else                     stall_i = 6'($urandom_range(0, 63));
         sample();
         chk($sformatf("%s.b%0d_cyc", tag, b),  32'(wb_cyc_o),    32'd1);
         chk($sformatf("%s.b%0d_stb", tag, b),  32'(wb_stb_o),    32'd1);
         chk($sformatf("%s.b%0d_we", tag, b),   32'(wb_we_o),     32'(v.we));
         chk($sformatf("%s.b%0d_adr", tag, b),  wb_adr_o,         v.addr);
         chk($sformatf("%s.b%0d_sel", tag, b),  32'(wb_sel_o),    32'(v.sel));
         chk($sformatf("%s.b%0d_dat", tag, b),  wb_dat_o,         v.wdata);
         chk($sformatf("%s.b%0d_st", tag, b),   32'(dbg_state_o), 32'(ST_BUSY));
         chk($sformatf("%s.b%0d_stallreq", tag, b), 32'(stallreq_o),
             (b < v.exp_busy - 1) ? 32'd1 : 32'd0);
         chk($sformatf("%s.b%0d_data", tag, b), cpu_data_o,
             (b == v.exp_busy - 1) ? v.exp_rd : 32'h0);
      end

      // Pipeline held by other stages: a new request and stray acks must be
      // ignored while the read data stays visible.
      for (int w = 0; w < v.n_stall; w++) begin
         next_cycle();
         stall_i    = (w < v.n_stall - 1) ? 6'b000011 : 6'b0;
         cpu_ce_i   = 1'b1;
         cpu_addr_i = $urandom;
         wb_ack_i   = 1'b1;
         wb_dat_i   = $urandom;
         sample();
         chk($sformatf("%s.w%0d_data", tag, w),   cpu_data_o,       v.exp_rd);
         chk($sformatf("%s.w%0d_st", tag, w),     32'(dbg_state_o), 32'(ST_WAIT));
         chk($sformatf("%s.w%0d_cyc", tag, w),    32'(wb_cyc_o),    32'd0);
         chk($sformatf("%s.w%0d_stallreq", tag, w), 32'(stallreq_o), 32'd0);
         chk($sformatf("%s.w%0d_err", tag, w),    32'(bus_err_o),
             (w == 0 && v.exp_err) ? 32'd1 : 32'd0);
      end

      // Back in IDLE with the bus idle; a stray ack is ignored here too.
      next_cycle();
      cpu_ce_i = 1'b0;
      stall_i  = '0;
      wb_ack_i = 1'b1;
      wb_dat_i = $urandom;
      sample();
      chk({tag, ".end_st"},   32'(dbg_state_o), 32'(ST_IDLE));
      chk({tag, ".end_cyc"},  32'(wb_cyc_o),    32'd0);
      chk({tag, ".end_adr"},  wb_adr_o,         32'h0);
      chk({tag, ".end_data"}, cpu_data_o,       32'h0);
      chk({tag, ".end_err"},  32'(bus_err_o),
          (v.n_stall == 0 && v.exp_err) ? 32'd1 : 32'd0);
      wb_ack_i = 1'b0;
   endtask

   // ---------------------------------------------------------------- test
   initial begin
      vec_t v;

      //             we    addr   sel      wdata         rdata    wait stall exp_rd busy err
      tbl[0] = '{1'b0, 32'h10, 4'hF,    32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1, 1'b0};
      tbl[1] = '{1'b1, 32'h20, 4'b0011, 32'h12345678, 32'hFFFF0000, 3, 0, 32'h0,        4, 1'b0};
      tbl[2] = '{1'b0, 32'h30, 4'hF,    32'h0,        32'hA5A50001, 0, 4, 32'hA5A50001, 1, 1'b0};
      tbl[3] = '{1'b1, 32'h34, 4'b1100, 32'h87654321, 32'h5555AAAA, 1, 2, 32'h0,        2, 1'b0};
      tbl[4] = '{1'b0, 32'h44, 4'hF,    32'h0,        32'h11112222, 9, 0, 32'h0,        4, 1'b1};
      tbl[5] = '{1'b0, 32'h48, 4'h1,    32'h0,        32'h33334444, 4, 2, 32'h0,        4, 1'b1};
      tbl[6] = '{1'b0, 32'h4C, 4'hF,    32'h0,        32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 3, 1'b0};
      tbl[7] = '{1'b0, 32'h50, 4'hF,    32'h0,        32'h0BADF00D, 3, 0, 32'h0BADF00D, 4, 1'b0};

      // Reset state.
      idle_inputs();
      rst = 1'b1;
      sample();
      sample();
      chk("rst_cyc",      32'(wb_cyc_o),    32'd0);
      chk("rst_stb",      32'(wb_stb_o),    32'd0);
      chk("rst_adr",      wb_adr_o,         32'h0);
      chk("rst_dat",      wb_dat_o,         32'h0);
      chk("rst_err",      32'(bus_err_o),   32'd0);
      chk("rst_st",       32'(dbg_state_o), 32'(ST_IDLE));
      chk("rst_stallreq", 32'(stallreq_o),  32'd0);
      next_cycle();
      rst = 1'b0;

      // Directed table.
      for (int i = 0; i < 8; i++) begin
         run_xact(tbl[i], $sformatf("tbl%0d", i));
      end

      // Flush in the second BUSY cycle together with ack: flush wins.
      next_cycle();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h60; cpu_sel_i = 4'hF;
      sample();
      chk("fl_req_stallreq", 32'(stallreq_o), 32'd1);
      next_cycle();
      sample();
      chk("fl_b0_stallreq", 32'(stallreq_o), 32'd1);
      next_cycle();
      flush_i = 1'b1; wb_ack_i = 1'b1; wb_dat_i = 32'h13572468; stall_i = 6'b000011;
      sample();
      chk("fl_b1_stallreq", 32'(stallreq_o), 32'd0);
      chk("fl_b1_cyc",      32'(wb_cyc_o),   32'd1);
      next_cycle();
      idle_inputs();
      sample();
      chk("fl_after_cyc",  32'(wb_cyc_o),    32'd0);
      chk("fl_after_st",   32'(dbg_state_o), 32'(ST_IDLE));
      chk("fl_after_data", cpu_data_o,       32'h0);
      chk("fl_after_err",  32'(bus_err_o),   32'd0);

      // Flush in IDLE blocks a request.
      next_cycle();
      cpu_ce_i = 1'b1; flush_i = 1'b1; cpu_addr_i = 32'h64;
      sample();
      chk("fl_idle_stallreq", 32'(stallreq_o), 32'd0);
      next_cycle();
      idle_inputs();
      sample();
      chk("fl_idle_cyc", 32'(wb_cyc_o),    32'd0);
      chk("fl_idle_st",  32'(dbg_state_o), 32'(ST_IDLE));

      // Reset asserted while BUSY takes effect without a clock edge.
      next_cycle();
      cpu_ce_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h70; cpu_sel_i = 4'hF;
      cpu_data_i = 32'h0F0F0F0F;
      next_cycle();
      sample();
      chk("mr_busy_cyc", 32'(wb_cyc_o), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("mr_cyc",      32'(wb_cyc_o),    32'd0);
      chk("mr_stb",      32'(wb_stb_o),    32'd0);
      chk("mr_stallreq", 32'(stallreq_o),  32'd0);
      chk("mr_st",       32'(dbg_state_o), 32'(ST_IDLE));
      chk("mr_err",      32'(bus_err_o),   32'd0);
      next_cycle();
      idle_inputs();
      rst = 1'b0;
      sample();
      chk("mr_rel_err", 32'(bus_err_o), 32'd0);
      v = '{1'b0, 32'h74, 4'hF, 32'h0, 32'h600DCAFE, 1, 0, 32'h600DCAFE, 2, 1'b0};
      run_xact(v, "mr_next");

      // Randomized transactions against the model.
      for (int i = 0; i < 40; i++) begin
         v.we      = 1'($urandom_range(0, 1));
         v.addr    = $urandom;
         v.sel     = 4'($urandom_range(0, 15));
         v.wdata   = $urandom;
         v.rdata   = $urandom;
         v.n_wait  = $urandom_range(0, 5);
         v.n_stall = $urandom_range(0, 3);
         v = model(v);
         run_xact(v, $sformatf("rnd%0d", i));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
